// File: rtl/conv_cop_pkg.sv
// Shared constants for the queued convolution coprocessor: opcodes, FSM state
// encodings, status bit positions and an opcode classifier.
package conv_cop_pkg;

    localparam logic [3:0] OP_READ      = 4'b0001;
    localparam logic [3:0] OP_WRITE     = 4'b0010;
    localparam logic [3:0] OP_CONV      = 4'b0101;
    localparam logic [3:0] OP_CONV_TRSP = 4'b0110;
    localparam logic [3:0] OP_CONV_ROB  = 4'b0111;
    localparam logic [3:0] OP_B2G       = 4'b1000;

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_MEMORY    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    localparam int STAT_OVERFLOW = 0;
    localparam int STAT_TIMEOUT  = 1;
    localparam int STAT_ILLEGAL  = 2;

    typedef enum logic [1:0] {
        OPC_MEM,
        OPC_ARITH,
        OPC_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [3:0] op);
        case (op)
            OP_READ, OP_WRITE:                          return OPC_MEM;
            OP_CONV, OP_CONV_TRSP, OP_CONV_ROB, OP_B2G: return OPC_ARITH;
            default:                                    return OPC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/conv_coprocessor_queued_if.sv
// Bundle of the coprocessor's HPS, register-bank and arithmetic-unit signals;
// master is the system side, slave is the coprocessor side.
interface conv_coprocessor_queued_if #(
    parameter int OPW = 200
);
    logic [31:0]    instruction;
    logic           activate_instruction;
    logic           wait_signal;
    logic           idle;
    logic [15:0]    output_reg;
    logic           output_valid;
    logic [2:0]     status;
    logic           clear_status;
    logic [5:0]     bank_addr;
    logic [15:0]    bank_wdata;
    logic           bank_we;
    logic [15:0]    bank_rdata;
    logic [OPW-1:0] bank_matrix_A;
    logic [OPW-1:0] bank_matrix_B;
    logic           result_we;
    logic           ipu_request;
    logic [OPW-1:0] external_matrix_A;
    logic [OPW-1:0] external_matrix_B;
    logic [OPW-1:0] operand_A;
    logic [OPW-1:0] operand_B;
    logic           unit_start;
    logic           unit_sel;
    logic [1:0]     unit_mode;
    logic           unit_done;
    logic [3:0]     opcode;
    logic [31:0]    fetched_instruction_ipu;

    modport master (
        output instruction, activate_instruction, clear_status, bank_rdata,
               bank_matrix_A, bank_matrix_B, ipu_request, external_matrix_A,
               external_matrix_B, unit_done,
        input  wait_signal, idle, output_reg, output_valid, status, bank_addr,
               bank_wdata, bank_we, result_we, operand_A, operand_B, unit_start,
               unit_sel, unit_mode, opcode, fetched_instruction_ipu
    );

    modport slave (
        input  instruction, activate_instruction, clear_status, bank_rdata,
               bank_matrix_A, bank_matrix_B, ipu_request, external_matrix_A,
               external_matrix_B, unit_done,
        output wait_signal, idle, output_reg, output_valid, status, bank_addr,
               bank_wdata, bank_we, result_we, operand_A, operand_B, unit_start,
               unit_sel, unit_mode, opcode, fetched_instruction_ipu
    );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous instruction queue; a push is refused when full even if a pop
// happens in the same cycle, and the head word is visible without a pop.
module instr_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/conv_coprocessor_queued.sv
// Queued HPS coprocessor: instructions are buffered, then fetched, decoded and
// either served from the register bank or dispatched to the matrix units.
module conv_coprocessor_queued
    import conv_cop_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MAT_N      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023,
    localparam int OPW       = MAT_N * MAT_N * DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    instruction,
    input  logic           activate_instruction,
    output logic           wait_signal,
    output logic           idle,
    output logic [15:0]    output_reg,
    output logic           output_valid,
    output logic [2:0]     status,
    input  logic           clear_status,
    output logic [5:0]     bank_addr,
    output logic [15:0]    bank_wdata,
    output logic           bank_we,
    input  logic [15:0]    bank_rdata,
    input  logic [OPW-1:0] bank_matrix_A,
    input  logic [OPW-1:0] bank_matrix_B,
    output logic           result_we,
    input  logic           ipu_request,
    input  logic [OPW-1:0] external_matrix_A,
    input  logic [OPW-1:0] external_matrix_B,
    output logic [OPW-1:0] operand_A,
    output logic [OPW-1:0] operand_B,
    output logic           unit_start,
    output logic           unit_sel,
    output logic [1:0]     unit_mode,
    input  logic           unit_done,
    output logic [3:0]     opcode,
    output logic [31:0]    fetched_instruction_ipu
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [31:0]      fetched_q, fetched_d;
    logic [15:0]      output_reg_q, output_reg_d;
    logic             output_valid_q, output_valid_d;
    logic [2:0]       status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_pop;

    assign fifo_pop = (state_q == ST_FETCH);

    instr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (activate_instruction),
        .din_i   (instruction),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        fetched_d      = fetched_q;
        output_reg_d   = output_reg_q;
        output_valid_d = 1'b0;
        cnt_d          = cnt_q;
        // Clear is applied first so any set event in the same cycle survives.
        status_d       = clear_status ? 3'b000 : status_q;
        if (activate_instruction && fifo_full) status_d[STAT_OVERFLOW] = 1'b1;

        case (state_q)
            ST_FETCH: begin
                if (!fifo_empty) begin
                    fetched_d = fifo_dout;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (classify(fetched_q[3:0]))
                    OPC_MEM:   state_d = ST_MEMORY;
                    OPC_ARITH: state_d = ST_EXECUTE;
                    default: begin
                        state_d                = ST_FETCH;
                        status_d[STAT_ILLEGAL] = 1'b1;
                    end
                endcase
            end
            ST_MEMORY: begin
                if (fetched_q[3:0] == OP_READ) begin
                    output_reg_d   = bank_rdata;
                    output_valid_d = 1'b1;
                end
                state_d = ST_FETCH;
            end
            ST_EXECUTE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (unit_done) begin
                    state_d = ST_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d                = ST_FETCH;
                    status_d[STAT_TIMEOUT] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_FETCH;
            fetched_q      <= '0;
            output_reg_q   <= '0;
            output_valid_q <= 1'b0;
            status_q       <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            fetched_q      <= fetched_d;
            output_reg_q   <= output_reg_d;
            output_valid_q <= output_valid_d;
            status_q       <= status_d;
            cnt_q          <= cnt_d;
        end
    end

    assign wait_signal             = fifo_full;
    assign idle                    = fifo_empty && (state_q == ST_FETCH);
    assign output_reg              = output_reg_q;
    assign output_valid            = output_valid_q;
    assign status                  = status_q;
    assign opcode                  = fetched_q[3:0];
    assign bank_addr               = fetched_q[9:4];
    assign bank_wdata              = fetched_q[25:10];
    assign fetched_instruction_ipu = fetched_q;
    assign bank_we                 = (state_q == ST_MEMORY) && (fetched_q[3:0] == OP_WRITE);
    assign unit_start              = (state_q == ST_EXECUTE);
    assign unit_sel                = (fetched_q[3:0] == OP_B2G);
    assign unit_mode               = fetched_q[1:0];
    assign result_we               = (state_q == ST_WAIT_DONE) && unit_done;
    assign operand_A               = ipu_request ? external_matrix_A : bank_matrix_A;
    assign operand_B               = ipu_request ? external_matrix_B : bank_matrix_B;

endmodule

// File: tb/tb_conv_coprocessor_queued.sv
// Scoreboard bench: stimulus pushes expected bank/unit/read events from a
// behavioural model; a monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_conv_coprocessor_queued;
    localparam int DATA_W     = 8;
    localparam int MAT_N      = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 1023;
    localparam int OPW        = MAT_N * MAT_N * DATA_W;
    localparam int NEVER      = 100000;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ST  = 2;
    localparam int K_RES = 3;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_coprocessor_queued_if #(.OPW(OPW)) bus ();

    logic [15:0] rom [64];
    assign bus.bank_rdata = rom[bus.bank_addr];

    ev_t exp_q[$];
    int  delay_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    conv_coprocessor_queued #(
        .DATA_W(DATA_W), .MAT_N(MAT_N), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .instruction             (bus.instruction),
        .activate_instruction    (bus.activate_instruction),
        .wait_signal             (bus.wait_signal),
        .idle                    (bus.idle),
        .output_reg              (bus.output_reg),
        .output_valid            (bus.output_valid),
        .status                  (bus.status),
        .clear_status            (bus.clear_status),
        .bank_addr               (bus.bank_addr),
        .bank_wdata              (bus.bank_wdata),
        .bank_we                 (bus.bank_we),
        .bank_rdata              (bus.bank_rdata),
        .bank_matrix_A           (bus.bank_matrix_A),
        .bank_matrix_B           (bus.bank_matrix_B),
        .result_we               (bus.result_we),
        .ipu_request             (bus.ipu_request),
        .external_matrix_A       (bus.external_matrix_A),
        .external_matrix_B       (bus.external_matrix_B),
        .operand_A               (bus.operand_A),
        .operand_B               (bus.operand_B),
        .unit_start              (bus.unit_start),
        .unit_sel                (bus.unit_sel),
        .unit_mode               (bus.unit_mode),
        .unit_done               (bus.unit_done),
        .opcode                  (bus.opcode),
        .fetched_instruction_ipu (bus.fetched_instruction_ipu)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endfunction

    function automatic void chk_wide(input string nm, input logic [OPW-1:0] act, input logic [OPW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] addr, input logic [15:0] data);
        logic [5:0] top = 6'($urandom);
        return {top, data, addr, op};
    endfunction

    function automatic logic [OPW-1:0] rand_opw();
        logic [OPW-1:0] r;
        for (int i = 0; i < OPW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Reference model: what an accepted instruction must make the coprocessor do.
    task automatic expect_instr(input logic [31:0] w, input int dly);
        ev_t e;
        logic arith = 1'b1;
        e.a = '0;
        e.b = '0;
        e.kind = K_ST;
        case (w[3:0])
            4'b0101: e.b = 16'd1;
            4'b0110: e.b = 16'd2;
            4'b0111: e.b = 16'd3;
            4'b1000: e.a = 16'd1;
            default: arith = 1'b0;
        endcase
        if (arith) begin
            exp_q.push_back(e);
            delay_q.push_back(dly);
            if (dly < TIMEOUT) begin
                e.kind = K_RES; e.a = '0; e.b = '0;
                exp_q.push_back(e);
            end
        end else if (w[3:0] == 4'b0001) begin
            e.kind = K_RD; e.a = rom[w[9:4]]; e.b = '0;
            exp_q.push_back(e);
        end else if (w[3:0] == 4'b0010) begin
            e.kind = K_WR; e.a = {10'd0, w[9:4]}; e.b = w[25:10];
            exp_q.push_back(e);
        end
    endtask

    task automatic push(input logic [31:0] w, input int dly, input bit accepted);
        bus.instruction          = w;
        bus.activate_instruction = 1'b1;
        if (accepted) expect_instr(w, dly);
        @(negedge clk);
        bus.activate_instruction = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input string nm);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (bus.idle && exp_q.size() == 0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_drain: idle=%0b pending=%0d, required idle=1 pending=0", nm, bus.idle, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int max_cyc, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.unit_start) seen = 1'b1;
        end
        chk({nm, "_start_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic take(input int kind, input logic [15:0] a, input logic [15:0] b, input string nm);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected event a=0x%0h b=0x%0h, required none", nm, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                n_err++;
                $display("FAIL %s: got kind=%0d a=0x%0h b=0x%0h, required kind=%0d a=0x%0h b=0x%0h",
                         nm, kind, a, b, e.kind, e.a, e.b);
            end else begin
                $display("txn %s a=0x%0h b=0x%0h ok", nm, a, b);
            end
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.bank_we === 1'b1)      take(K_WR, {10'd0, bus.bank_addr}, bus.bank_wdata, "bank_write");
            if (bus.output_valid === 1'b1) take(K_RD, bus.output_reg, 16'd0, "read_result");
            if (bus.unit_start === 1'b1)   take(K_ST, {15'd0, bus.unit_sel}, {14'd0, bus.unit_mode}, "unit_start");
            if (bus.result_we === 1'b1)    take(K_RES, 16'd0, 16'd0, "result_we");
        end
    end

    // Arithmetic unit responder: answers each unit_start after its scheduled delay.
    initial begin
        bus.unit_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.unit_start === 1'b1) begin
                int d;
                d = (delay_q.size() == 0) ? NEVER : delay_q.pop_front();
                if (d < TIMEOUT) begin
                    repeat (d) @(posedge clk);
                    #1 bus.unit_done = 1'b1;
                    @(posedge clk);
                    #1 bus.unit_done = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  legal_ops [6];
        logic [3:0]  op;
        logic [OPW-1:0] ma, mb, ea, eb;
        int  lat;
        bit  got;
        bit  any_ill;

        legal_ops = '{4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        rom[5] = 16'h1234;
        reset = 1'b1;
        bus.instruction          = '0;
        bus.activate_instruction = 1'b0;
        bus.clear_status         = 1'b0;
        bus.ipu_request          = 1'b0;
        bus.bank_matrix_A        = '0;
        bus.bank_matrix_B        = '0;
        bus.external_matrix_A    = '0;
        bus.external_matrix_B    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_status", 64'(bus.status), 64'd0);
        chk("rst_idle", 64'(bus.idle), 64'd1);
        chk("rst_wait", 64'(bus.wait_signal), 64'd0);
        chk("rst_output_reg", 64'(bus.output_reg), 64'd0);
        chk("rst_output_valid", 64'(bus.output_valid), 64'd0);
        chk("rst_fetched", 64'(bus.fetched_instruction_ipu), 64'd0);
        chk("rst_strobes", 64'({bus.bank_we, bus.unit_start, bus.result_we}), 64'd0);

        // WRITE addr 5 data 0x00AB
        w = mk(4'b0010, 6'd5, 16'h00AB);
        push(w, 0, 1'b1);
        wait_drain(20, "write");
        chk("write_idle", 64'(bus.idle), 64'd1);
        chk("write_opcode", 64'(bus.opcode), 64'h2);
        chk("write_fetched", 64'(bus.fetched_instruction_ipu), 64'(w));

        // READ addr 5 with latency measured from the push cycle
        push(mk(4'b0001, 6'd5, 16'h0), 0, 1'b1);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.output_valid) got = 1'b1;
        end
        chk("read_latency", 64'(lat), 64'd4);
        chk("read_value", 64'(bus.output_reg), 64'h1234);
        @(negedge clk);
        chk("read_valid_pulse", 64'(bus.output_valid), 64'd0);
        wait_drain(20, "read");

        // CONV_ROB finishing 10 cycles after unit_start
        push(mk(4'b0111, 6'($urandom), 16'($urandom)), 10, 1'b1);
        wait_drain(40, "conv_rob");

        // Illegal opcode with clear_status held: the set must win, then stick
        push(mk(4'b1111, 6'd0, 16'd0), 0, 1'b0);
        bus.clear_status = 1'b1;
        @(negedge clk);
        chk("illegal_before_decode", 64'(bus.status), 64'b000);
        @(negedge clk);
        chk("illegal_set_over_clear", 64'(bus.status), 64'b100);
        bus.clear_status = 1'b0;
        @(negedge clk);
        chk("illegal_sticky", 64'(bus.status), 64'b100);
        bus.clear_status = 1'b1;
        @(negedge clk);
        bus.clear_status = 1'b0;
        chk("illegal_cleared", 64'(bus.status), 64'b000);
        wait_drain(20, "illegal");

        // Overflow: unit busy, four words fill the queue, the fifth is dropped
        push(mk(4'b0101, 6'd0, 16'd0), 40, 1'b1);
        wait_start(20, "ovf");
        for (int i = 0; i < 5; i++) begin
            push(mk(4'b0001, 6'($urandom), 16'($urandom)), 0, i < FIFO_DEPTH);
            if (i == FIFO_DEPTH - 1) chk("ovf_wait_signal", 64'(bus.wait_signal), 64'd1);
        end
        chk("ovf_status", 64'(bus.status), 64'b001);
        wait_drain(200, "ovf");
        chk("ovf_queue_empty_wait", 64'(bus.wait_signal), 64'd0);
        bus.clear_status = 1'b1;
        @(negedge clk);
        bus.clear_status = 1'b0;

        // B2G timeout followed by a queued READ
        push(mk(4'b1000, 6'd0, 16'd0), NEVER, 1'b1);
        push(mk(4'b0001, 6'($urandom), 16'd0), 0, 1'b1);
        wait_start(20, "tmo");
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < TIMEOUT + 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.status[1]) got = 1'b1;
        end
        chk("tmo_cycles", 64'(lat), 64'(TIMEOUT + 1));
        wait_drain(50, "tmo");
        chk("tmo_status", 64'(bus.status), 64'b010);
        bus.clear_status = 1'b1;
        @(negedge clk);
        bus.clear_status = 1'b0;

        // Reset during WAIT_DONE: the late unit_done must produce nothing
        push(mk(4'b0110, 6'd0, 16'd0), 20, 1'b1);
        wait_start(20, "rst_wait");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_idle", 64'(bus.idle), 64'd1);
        chk("midrst_status", 64'(bus.status), 64'd0);
        repeat (40) @(negedge clk);

        // Operand source select
        for (int i = 0; i < 2; i++) begin
            ma = rand_opw(); mb = rand_opw(); ea = rand_opw(); eb = rand_opw();
            bus.bank_matrix_A = ma; bus.bank_matrix_B = mb;
            bus.external_matrix_A = ea; bus.external_matrix_B = eb;
            bus.ipu_request = 1'(i);
            #1;
            chk_wide("operand_A", bus.operand_A, (i == 1) ? ea : ma);
            chk_wide("operand_B", bus.operand_B, (i == 1) ? eb : mb);
            @(negedge clk);
        end
        bus.ipu_request = 1'b0;

        // Randomized instruction stream
        any_ill = 1'b0;
        for (int n = 0; n < 150; n++) begin
            int d;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                if (!bus.wait_signal) got = 1'b1;
                else @(negedge clk);
            end
            chk("rand_queue_space", 64'(got), 64'd1);
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
            else op = legal_ops[$urandom_range(0, 5)];
            if (!(op inside {4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111, 4'b1000})) any_ill = 1'b1;
            d = $urandom_range(1, 15);
            push(mk(op, 6'($urandom), 16'($urandom)), d, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(2000, "random");
        chk("rand_status", 64'(bus.status), 64'({any_ill, 2'b00}));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_coprocessor_queued.md
CONV_COPROCESSOR_QUEUED -- requirements
Module: conv_coprocessor_queued

Interface
REQ-001 SHALL have parameter DATA_W, default 8, matrix element width in bits.
REQ-002 SHALL have parameter MAT_N, default 5, matrix side; operand width OPW = MAT_N*MAT_N*DATA_W.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum execute-wait cycles.
REQ-005 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-high reset (the only clock and reset).
REQ-006 SHALL have ports: instruction in 32, HPS instruction word; activate_instruction in 1, push request; wait_signal out 1, queue full; idle out 1, queue empty and FSM in FETCH.
REQ-007 SHALL have ports: output_reg out 16, READ result; output_valid out 1, one-cycle READ-complete pulse; status out 3, sticky {illegal, timeout, overflow}; clear_status in 1, clears status.
REQ-008 SHALL have ports: bank_addr out 6, bank_wdata out 16, bank_we out 1, bank_rdata in 16, bank_matrix_A in OPW, bank_matrix_B in OPW, result_we out 1.
REQ-009 SHALL have ports: ipu_request in 1, external_matrix_A in OPW, external_matrix_B in OPW, operand_A out OPW, operand_B out OPW.
REQ-010 SHALL have ports: unit_start out 1, unit_sel out 1 (0 conv, 1 bayer2grey), unit_mode out 2, unit_done in 1, opcode out 4, fetched_instruction_ipu out 32.

Function
REQ-011 Opcodes = instruction[3:0]: READ 0001, WRITE 0010, CONV 0101, CONV_TRSP 0110, CONV_ROB 0111, B2G 1000; any other value SHALL be illegal.
REQ-012 Push: activate_instruction with queue not full SHALL enqueue instruction that cycle; when full the word SHALL be dropped and status[0] set.
REQ-013 Fullness SHALL be evaluated before a same-cycle pop (no push-through when full); push into empty queue SHALL NOT bypass to FETCH the same cycle.
REQ-014 FSM states FETCH, DECODE, MEMORY, EXECUTE, WAIT_DONE; FETCH with queue non-empty SHALL pop head into fetched_instruction and go DECODE; else stay FETCH.
REQ-015 DECODE SHALL go MEMORY for READ/WRITE, EXECUTE for arithmetic opcodes, FETCH with status[2] set for illegal opcodes.
REQ-016 bank_addr = fetched_instruction[9:4], bank_wdata = fetched_instruction[25:10], opcode = fetched_instruction[3:0], continuously.
REQ-017 MEMORY SHALL last one cycle: bank_we high iff WRITE; for READ output_reg <= bank_rdata and output_valid pulses next cycle; then FETCH.
REQ-018 EXECUTE SHALL pulse unit_start one cycle with unit_sel = (opcode==B2G), unit_mode = opcode[1:0], then enter WAIT_DONE.
REQ-019 WAIT_DONE: unit_done SHALL pulse result_we for one cycle and go FETCH; unit_done outside WAIT_DONE SHALL be ignored.
REQ-020 WAIT_DONE counter SHALL reset on entry; reaching TIMEOUT without unit_done SHALL set status[1] and go FETCH with no result_we.
REQ-021 operand_A/B SHALL equal external_matrix_A/B when ipu_request high, else bank_matrix_A/B (combinational).
REQ-022 wait_signal = queue full; idle = queue empty AND state FETCH.
REQ-023 clear_status SHALL zero status next cycle; a same-cycle set event SHALL win over clear.
REQ-024 fetched_instruction_ipu SHALL equal fetched_instruction.
REQ-025 Worst-case latency push-to-memory-complete from empty idle: 4 cycles (push, FETCH, DECODE, MEMORY).

Reset
REQ-026 reset SHALL empty the queue, force FETCH, clear counter, and zero fetched_instruction, output_reg, output_valid, status, unit_start, bank_we, result_we.
REQ-027 reset mid-WAIT_DONE SHALL abandon the operation; a later unit_done SHALL NOT produce result_we.

Structure
REQ-028 Opcode constants, state encodings and status bit indices SHALL live in shared package conv_cop_pkg.
REQ-029 Queue SHALL be sub-module instr_fifo (parameter FIFO_DEPTH, 32-bit, synchronous, full/empty flags).

Verification
REQ-030 Reset, push WRITE addr 5 data 0x00AB -> bank_we one cycle with bank_addr 5, bank_wdata 0x00AB, idle returns high.
REQ-031 Push READ addr 5, bank_rdata 0x1234 -> output_reg 0x1234 with one output_valid pulse, 4 cycles after push.
REQ-032 Push 5 words back-to-back, unit_done held low, FIFO_DEPTH 4 -> wait_signal high, fifth dropped, status = 001.
REQ-033 Push CONV_ROB, unit_done 10 cycles after unit_start -> unit_sel 0, unit_mode 11, one result_we pulse.
REQ-034 Push B2G, never assert unit_done -> status[1] set after 1023 WAIT_DONE cycles, FSM returns FETCH, next queued READ completes.
REQ-035 Push opcode 1111 -> status = 100, no unit_start; clear_status -> status 000.
